// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile write-port arbiter.
// This package takes over the register-file geometry that core.svh held
// (REG_NUM, data width) and adds the default starvation limit.
package regfile_wb_arbiter_pkg;

  localparam int REG_NUM_DEFAULT      = 32;
  localparam int DATA_W_DEFAULT       = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Holding-buffer occupancy / starvation state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no buffered MDU result
    ST_WAIT  = 2'd1,  // result buffered, port not yet forced
    ST_FORCE = 2'd2   // result buffered, blocked long enough: hold the pipe
  } starve_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Busy scoreboard for outstanding MDU results plus the decode hazard check.
// A register whose MDU result is written this very cycle is not considered
// busy, because regfile forwards the write data to decode in the same cycle.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEFAULT,
  parameter int RF_W    = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [RF_W-1:0] issue_regid,
  input  logic            clr_valid,
  input  logic [RF_W-1:0] clr_regid,
  input  logic [RF_W-1:0] dec_rs1_regid,
  input  logic [RF_W-1:0] dec_rs2_regid,
  input  logic [RF_W-1:0] dec_rd_regid,
  input  logic            dec_rd_write,
  output logic            hazard_stall
);

  logic [REG_NUM-1:0] r_busy;
  logic               w_rs1_busy;
  logic               w_rs2_busy;
  logic               w_rd_busy;

  // Busy only while the register is not being written this cycle.
  function automatic logic eff_busy(input logic [RF_W-1:0] id);
    return r_busy[id] & ~(clr_valid && (clr_regid == id));
  endfunction

  // Set on issue, clear on MDU writeback; set wins, register 0 never tracked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (r == 0)
          r_busy[r] <= 1'b0;
        else if (issue_valid && (issue_regid == RF_W'(r)))
          r_busy[r] <= 1'b1;
        else if (clr_valid && (clr_regid == RF_W'(r)))
          r_busy[r] <= 1'b0;
      end
    end
  end

  assign w_rs1_busy   = eff_busy(dec_rs1_regid);
  assign w_rs2_busy   = eff_busy(dec_rs2_regid);
  // The rd term stops a younger write from overtaking an outstanding MDU write.
  assign w_rd_busy    = dec_rd_write & eff_busy(dec_rd_regid);
  assign hazard_stall = w_rs1_busy | w_rs2_busy | w_rd_busy;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the in-order WB stage and
// the MDU. MDU results land in a one-entry buffer that drains into idle port
// cycles; if the pipeline keeps the port busy for STARVE_LIMIT cycles the
// buffer forces its write and holds the WB stage for one cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int REG_NUM      = REG_NUM_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int RF_W         = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_write,
  input  logic [RF_W-1:0]   pipe_wb_regid,
  input  logic [DATA_W-1:0] pipe_wb_writedata,
  output logic              pipe_hold,
  input  logic              mdu_valid,
  input  logic [RF_W-1:0]   mdu_regid,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic              issue_valid,
  input  logic [RF_W-1:0]   issue_regid,
  input  logic [RF_W-1:0]   dec_rs1_regid,
  input  logic [RF_W-1:0]   dec_rs2_regid,
  input  logic [RF_W-1:0]   dec_rd_regid,
  input  logic              dec_rd_write,
  output logic              hazard_stall,
  output logic              wb_write,
  output logic [RF_W-1:0]   wb_regid,
  output logic [DATA_W-1:0] wb_writedata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  starve_state_e     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [RF_W-1:0]   r_buf_regid;
  logic [DATA_W-1:0] r_buf_data;

  logic w_run;
  logic w_buf_valid;
  logic w_mdu_hs;
  logic w_buf_write;
  logic w_sb_stall;

  // While reset is asserted the outputs fall back to the idle values and the
  // buffer is never written out, so a discarded result cannot reach regfile.
  assign w_run       = rst;
  assign w_buf_valid = (r_state != ST_EMPTY);
  assign mdu_ready   = ~w_run | ~w_buf_valid;
  assign w_mdu_hs    = mdu_valid & mdu_ready;
  assign pipe_hold   = w_run & (r_state == ST_FORCE);

  // Buffer wins when forced, or whenever the pipeline leaves the port idle.
  assign w_buf_write  = w_run & w_buf_valid & (pipe_hold | ~pipe_wb_write);
  assign wb_write     = w_buf_write | (pipe_wb_write & ~pipe_hold);
  assign wb_regid     = w_buf_write ? r_buf_regid : pipe_wb_regid;
  assign wb_writedata = w_buf_write ? r_buf_data  : pipe_wb_writedata;

  // Occupancy / starvation FSM: counts cycles the buffered result is blocked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_mdu_hs) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (w_buf_write) begin
            r_state <= ST_EMPTY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if ((r_cnt + 1'b1) == LIMIT)
              r_state <= ST_FORCE;
          end
        end
        ST_FORCE: begin
          r_state <= ST_EMPTY;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_EMPTY;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Capture the MDU result payload on handshake; occupancy lives in r_state.
  always_ff @(posedge clk) begin
    if (w_mdu_hs) begin
      r_buf_regid <= mdu_regid;
      r_buf_data  <= mdu_data;
    end
  end

  wb_scoreboard #(
    .REG_NUM (REG_NUM),
    .RF_W    (RF_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_regid   (issue_regid),
    .clr_valid     (w_buf_write),
    .clr_regid     (r_buf_regid),
    .dec_rs1_regid (dec_rs1_regid),
    .dec_rs2_regid (dec_rs2_regid),
    .dec_rd_regid  (dec_rd_regid),
    .dec_rd_write  (dec_rd_write),
    .hazard_stall  (w_sb_stall)
  );

  assign hazard_stall = w_run & w_sb_stall;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (REG_NUM=32, STARVE_LIMIT=4).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_write;
  logic [4:0]  pipe_wb_regid;
  logic [31:0] pipe_wb_writedata;
  logic        pipe_hold;
  logic        mdu_valid;
  logic [4:0]  mdu_regid;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_regid;
  logic [4:0]  dec_rs1_regid;
  logic [4:0]  dec_rs2_regid;
  logic [4:0]  dec_rd_regid;
  logic        dec_rd_write;
  logic        hazard_stall;
  logic        wb_write;
  logic [4:0]  wb_regid;
  logic [31:0] wb_writedata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .REG_NUM      (32),
    .STARVE_LIMIT (4),
    .DATA_W       (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pipe_wb_write     (pipe_wb_write),
    .pipe_wb_regid     (pipe_wb_regid),
    .pipe_wb_writedata (pipe_wb_writedata),
    .pipe_hold         (pipe_hold),
    .mdu_valid         (mdu_valid),
    .mdu_regid         (mdu_regid),
    .mdu_data          (mdu_data),
    .mdu_ready         (mdu_ready),
    .issue_valid       (issue_valid),
    .issue_regid       (issue_regid),
    .dec_rs1_regid     (dec_rs1_regid),
    .dec_rs2_regid     (dec_rs2_regid),
    .dec_rd_regid      (dec_rd_regid),
    .dec_rd_write      (dec_rd_write),
    .hazard_stall      (hazard_stall),
    .wb_write          (wb_write),
    .wb_regid          (wb_regid),
    .wb_writedata      (wb_writedata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; new inputs then apply to the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    pipe_wb_write = 1'b0; pipe_wb_regid = '0; pipe_wb_writedata = '0;
    mdu_valid = 1'b0; mdu_regid = '0; mdu_data = '0;
    issue_valid = 1'b0; issue_regid = '0;
    dec_rs1_regid = '0; dec_rs2_regid = '0; dec_rd_regid = '0; dec_rd_write = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    pipe_wb_write = 1'b1; pipe_wb_regid = 5'd3; pipe_wb_writedata = 32'h7;
    dec_rs1_regid = 5'd5;
    #1;
    chk("rst_mdu_ready", mdu_ready, 1);
    chk("rst_pipe_hold", pipe_hold, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_wb_write", wb_write, 1);
    chk("rst_wb_regid", wb_regid, 3);
    pipe_wb_write = 1'b0; dec_rs1_regid = '0;
    #1;
    chk("rst_wb_idle", wb_write, 0);
    tick();
    rst = 1'b1;

    // ---------------- idle MDU write ----------------
    issue_valid = 1'b1; issue_regid = 5'd5;
    tick();
    issue_valid = 1'b0; dec_rs1_regid = 5'd5;
    mdu_valid = 1'b1; mdu_regid = 5'd5; mdu_data = 32'h1234;
    #1;
    chk("idle_busy5", hazard_stall, 1);
    chk("idle_ready", mdu_ready, 1);
    chk("idle_nowrite", wb_write, 0);
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("idle_wb_write", wb_write, 1);
    chk("idle_wb_regid", wb_regid, 5);
    chk("idle_wb_data", wb_writedata, 32'h1234);
    chk("idle_ready_low", mdu_ready, 0);
    chk("idle_fwd_nostall", hazard_stall, 0);
    tick();
    chk("idle_ready_again", mdu_ready, 1);
    chk("idle_wb_done", wb_write, 0);
    chk("idle_busy_clr", hazard_stall, 0);
    dec_rs1_regid = '0;

    // ---------------- pipeline priority ----------------
    issue_valid = 1'b1; issue_regid = 5'd7;
    tick();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_regid = 5'd7; mdu_data = 32'h77;
    tick();
    mdu_valid = 1'b0;
    pipe_wb_write = 1'b1; pipe_wb_regid = 5'd3; pipe_wb_writedata = 32'hAA;
    dec_rs1_regid = 5'd7;
    #1;
    chk("prio_wb_regid", wb_regid, 3);
    chk("prio_wb_data", wb_writedata, 32'hAA);
    chk("prio_no_hold", pipe_hold, 0);
    chk("prio_ready_low", mdu_ready, 0);
    chk("prio_busy7", hazard_stall, 1);
    tick();
    pipe_wb_write = 1'b0;
    #1;
    chk("prio_buf_write", wb_write, 1);
    chk("prio_buf_regid", wb_regid, 7);
    chk("prio_buf_data", wb_writedata, 32'h77);
    chk("prio_fwd_nostall", hazard_stall, 0);
    tick();
    chk("prio_ready_again", mdu_ready, 1);
    dec_rs1_regid = '0;

    // ---------------- starvation ----------------
    issue_valid = 1'b1; issue_regid = 5'd9;
    tick();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_regid = 5'd9; mdu_data = 32'h99;
    pipe_wb_write = 1'b1; pipe_wb_regid = 5'd1; pipe_wb_writedata = 32'h100;
    #1;
    chk("starve_load_pipe", wb_regid, 1);
    tick();
    mdu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pipe_wb_writedata = 32'h100 + 32'(k);
      #1;
      chk("starve_blocked_hold", pipe_hold, 0);
      chk("starve_blocked_regid", wb_regid, 1);
      chk("starve_blocked_data", wb_writedata, 32'h100 + 32'(k));
      tick();
    end
    chk("starve_force_hold", pipe_hold, 1);
    chk("starve_force_write", wb_write, 1);
    chk("starve_force_regid", wb_regid, 9);
    chk("starve_force_data", wb_writedata, 32'h99);
    tick();
    chk("starve_after_hold", pipe_hold, 0);
    chk("starve_after_ready", mdu_ready, 1);
    chk("starve_after_regid", wb_regid, 1);
    pipe_wb_write = 1'b0;

    // ---------------- scoreboard stall ----------------
    issue_valid = 1'b1; issue_regid = 5'd12;
    tick();
    issue_valid = 1'b0; dec_rs1_regid = 5'd12;
    #1;
    chk("sb_stall_1", hazard_stall, 1);
    tick();
    chk("sb_stall_2", hazard_stall, 1);
    mdu_valid = 1'b1; mdu_regid = 5'd12; mdu_data = 32'hC;
    #1;
    chk("sb_stall_hs", hazard_stall, 1);
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("sb_wb_write", wb_write, 1);
    chk("sb_wb_regid", wb_regid, 12);
    chk("sb_stall_drop", hazard_stall, 0);
    tick();
    chk("sb_stall_gone", hazard_stall, 0);
    dec_rs1_regid = '0;

    // ---------------- zero register and WAW ----------------
    issue_valid = 1'b1; issue_regid = 5'd0;
    tick();
    issue_valid = 1'b0;
    dec_rd_regid = 5'd0; dec_rd_write = 1'b1;
    #1;
    chk("zero_no_stall", hazard_stall, 0);
    issue_valid = 1'b1; issue_regid = 5'd4;
    tick();
    issue_valid = 1'b0;
    dec_rd_regid = 5'd4; dec_rd_write = 1'b1;
    #1;
    chk("waw_stall", hazard_stall, 1);
    dec_rd_write = 1'b0;
    #1;
    chk("waw_no_write", hazard_stall, 0);
    dec_rs2_regid = 5'd4;
    #1;
    chk("rs2_stall", hazard_stall, 1);
    dec_rs2_regid = '0; dec_rd_regid = '0;
    mdu_valid = 1'b1; mdu_regid = 5'd4; mdu_data = 32'h44;
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("waw_drain_regid", wb_regid, 4);
    tick();

    // ---------------- reset mid-operation ----------------
    issue_valid = 1'b1; issue_regid = 5'd8;
    tick();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_regid = 5'd8; mdu_data = 32'h88;
    tick();
    mdu_valid = 1'b0; dec_rs1_regid = 5'd8;
    #1;
    chk("rmid_full", mdu_ready, 0);
    chk("rmid_writes_before", wb_write, 1);
    rst = 1'b0;
    #1;
    chk("rmid_inrst_wb", wb_write, 0);
    chk("rmid_inrst_ready", mdu_ready, 1);
    chk("rmid_inrst_hazard", hazard_stall, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("rmid_ready", mdu_ready, 1);
    chk("rmid_no_wb", wb_write, 0);
    chk("rmid_hazard", hazard_stall, 0);
    chk("rmid_hold", pipe_hold, 0);
    tick();
    chk("rmid_no_wb_later", wb_write, 0);
    chk("rmid_hazard_later", hazard_stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
